// File: rtl/disp_ctrl_pkg.sv
// Shared definitions for the display-selection controller: state encodings,
// button indices, press priority and the registered output decode.
package disp_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SHOW_A = 3'd1;
    localparam state_t ST_SHOW_B = 3'd2;
    localparam state_t ST_HOLD_A = 3'd3;
    localparam state_t ST_HOLD_B = 3'd4;
    localparam state_t ST_SCAN   = 3'd5;

    // Button indices into the press/level vectors.
    localparam int BTN_A    = 0;
    localparam int BTN_B    = 1;
    localparam int BTN_HOLD = 2;
    localparam int BTN_SCAN = 3;
    localparam int NUM_BTNS = 4;

    typedef enum logic [1:0] {
        PR_A    = 2'd0,
        PR_B    = 2'd1,
        PR_HOLD = 2'd2,
        PR_SCAN = 2'd3
    } press_sel_e;

    // Highest-priority press in a cycle: scan > hold > a > b.
    // Only meaningful when at least one press bit is set.
    function automatic press_sel_e top_press(input logic [NUM_BTNS-1:0] p);
        press_sel_e sel;
        if (p[BTN_SCAN])      sel = PR_SCAN;
        else if (p[BTN_HOLD]) sel = PR_HOLD;
        else if (p[BTN_A])    sel = PR_A;
        else                  sel = PR_B;
        return sel;
    endfunction

    // Mux controls {sela, selb, hold, seldisp} for a given state and scan phase.
    function automatic logic [3:0] out_decode(input state_t st, input logic phase);
        logic [3:0] o;
        case (st)
            ST_SHOW_A: o = 4'b1000;
            ST_SHOW_B: o = 4'b0100;
            ST_HOLD_A: o = 4'b0011;
            ST_HOLD_B: o = 4'b0010;
            ST_SCAN:   o = {3'b001, phase};
            default:   o = 4'b0000;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability counter. The debounced level
// follows the synchronised level only after it has differed for DEB_CYCLES
// consecutive cycles; a rising debounced level emits a one-cycle press pulse.
module btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;

    // Count consecutive cycles of disagreement; any agreement restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, counter, debounced level and press pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/disp_sel_ctrl.sv
// Display-selection controller: debounces four buttons, runs the selection
// FSM with its scan dwell and idle timeout counters, and registers the mux
// controls decoded from the next state.
module disp_sel_ctrl
    import disp_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int SCAN_SECS  = 4,
    parameter int IDLE_SECS  = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_a,
    input  logic       btn_b,
    input  logic       btn_hold,
    input  logic       btn_scan,
    output logic       sela,
    output logic       selb,
    output logic       hold,
    output logic       seldisp,
    output logic [2:0] state_o
);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] btn_press;

    assign btn_raw[BTN_A]    = btn_a;
    assign btn_raw[BTN_B]    = btn_b;
    assign btn_raw[BTN_HOLD] = btn_hold;
    assign btn_raw[BTN_SCAN] = btn_scan;

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_deb
            btn_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .clk    (clk),
                .rst    (rst),
                .btn_raw(btn_raw[gi]),
                .level  (btn_level[gi]),
                .press  (btn_press[gi])
            );
        end
    endgenerate

    // Debounced levels are not needed by the FSM; only the press pulses are.
    logic levels_unused;
    assign levels_unused = ^btn_level;

    state_t     state_q, state_d;
    logic       phase_q, phase_d;
    logic [7:0] dwell_q, dwell_d;
    logic [7:0] idle_q, idle_d;
    logic [3:0] out_q;

    logic       any_press;
    press_sel_e sel;
    logic [8:0] dwell_inc, idle_inc;

    assign any_press = |btn_press;
    assign sel       = top_press(btn_press);
    assign dwell_inc = {1'b0, dwell_q} + 9'd1;
    assign idle_inc  = {1'b0, idle_q} + 9'd1;

    // Next-state: a press always beats a coincident tick and clears both counters.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        dwell_d = dwell_q;
        idle_d  = idle_q;
        if (any_press) begin
            dwell_d = '0;
            idle_d  = '0;
            case (sel)
                PR_SCAN: begin
                    if (state_q == ST_SCAN) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SCAN;
                        phase_d = 1'b1;
                    end
                end
                PR_HOLD: begin
                    case (state_q)
                        ST_SHOW_A: state_d = ST_HOLD_A;
                        ST_SHOW_B: state_d = ST_HOLD_B;
                        ST_HOLD_A: state_d = ST_SHOW_A;
                        ST_HOLD_B: state_d = ST_SHOW_B;
                        default:   state_d = state_q;
                    endcase
                end
                PR_A:    state_d = ST_SHOW_A;
                default: state_d = ST_SHOW_B;
            endcase
        end else if (tick_1hz) begin
            if (state_q == ST_SCAN) begin
                if (dwell_inc == 9'(SCAN_SECS)) begin
                    phase_d = ~phase_q;
                    dwell_d = '0;
                end else begin
                    dwell_d = dwell_inc[7:0];
                end
            end else if ((state_q == ST_SHOW_A || state_q == ST_SHOW_B) && IDLE_SECS != 0) begin
                if (idle_inc == 9'(IDLE_SECS)) begin
                    state_d = ST_IDLE;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_inc[7:0];
                end
            end
        end
        // Counters only live in their own states and restart on any state change.
        if (state_d != ST_SCAN || state_d != state_q) begin
            dwell_d = '0;
        end
        if ((state_d != ST_SHOW_A && state_d != ST_SHOW_B) || state_d != state_q) begin
            idle_d = '0;
        end
    end

    // State, counters and outputs registered together so outputs track the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= 1'b0;
            dwell_q <= '0;
            idle_q  <= '0;
            out_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            dwell_q <= dwell_d;
            idle_q  <= idle_d;
            out_q   <= out_decode(state_d, phase_d);
        end
    end

    assign sela    = out_q[3];
    assign selb    = out_q[2];
    assign hold    = out_q[1];
    assign seldisp = out_q[0];
    assign state_o = state_q;

endmodule

// File: tb/tb_disp_sel_ctrl.sv
// Directed bench for disp_sel_ctrl with DEB_CYCLES=4, SCAN_SECS=2, IDLE_SECS=3.
module tb_disp_sel_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       btn_a = 1'b0, btn_b = 1'b0, btn_hold = 1'b0, btn_scan = 1'b0;
    logic       sela, selb, hold, seldisp;
    logic [2:0] state_o;
    logic [3:0] outs;

    int checks = 0;
    int errors = 0;

    disp_sel_ctrl #(
        .DEB_CYCLES(4),
        .SCAN_SECS (2),
        .IDLE_SECS (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tick_1hz(tick_1hz),
        .btn_a   (btn_a),
        .btn_b   (btn_b),
        .btn_hold(btn_hold),
        .btn_scan(btn_scan),
        .sela    (sela),
        .selb    (selb),
        .hold    (hold),
        .seldisp (seldisp),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    assign outs = {sela, selb, hold, seldisp};

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            0: btn_a = v;
            1: btn_b = v;
            2: btn_hold = v;
            default: btn_scan = v;
        endcase
    endtask

    // Full press: hold long enough for the FSM to act, then release and settle.
    task automatic press_release(input int idx);
        set_btn(idx, 1'b1);
        steps(7);
        set_btn(idx, 1'b0);
        steps(8);
    endtask

    task automatic pulse_tick();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
        steps(10);
        checks++;
        if ({outs, state_o} !== {4'b0000, 3'd0}) begin
            errors++;
            $display("FAIL reset_state: got outs=%b state=%0d, want outs=0000 state=0", outs, state_o);
        end
        $display("reset_state: outs=%b state=%0d", outs, state_o);
    endtask

    task automatic test_latency();
        btn_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (outs !== 4'b0000) begin
                errors++;
                $display("FAIL latency_early edge %0d: got outs=%b, want 0000", i, outs);
            end
        end
        step();
        checks++;
        if ({outs, state_o} !== {4'b1000, 3'd1}) begin
            errors++;
            $display("FAIL latency_edge6: got outs=%b state=%0d, want 1000 state=1", outs, state_o);
        end
        $display("latency: outs=%b state=%0d after edge 6", outs, state_o);
        btn_a = 1'b0;
        steps(8);
    endtask

    task automatic test_bounce();
        press_release(1);
        checks++;
        if (outs !== 4'b0100) begin
            errors++;
            $display("FAIL bounce_setup_b: got outs=%b, want 0100", outs);
        end
        btn_a = 1'b1;
        steps(3);
        btn_a = 1'b0;
        step();
        btn_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (outs !== 4'b0100) begin
                errors++;
                $display("FAIL bounce_early edge %0d: got outs=%b, want 0100", i, outs);
            end
        end
        step();
        checks++;
        if ({outs, state_o} !== {4'b1000, 3'd1}) begin
            errors++;
            $display("FAIL bounce_final: got outs=%b state=%0d, want 1000 state=1", outs, state_o);
        end
        $display("bounce: outs=%b state=%0d 6 edges after final rise", outs, state_o);
        btn_a = 1'b0;
        steps(8);
    endtask

    task automatic test_hold();
        press_release(1);
        checks++;
        if ({outs, state_o} !== {4'b0100, 3'd2}) begin
            errors++;
            $display("FAIL hold_show_b: got outs=%b state=%0d, want 0100 state=2", outs, state_o);
        end
        press_release(2);
        checks++;
        if ({outs, state_o} !== {4'b0010, 3'd4}) begin
            errors++;
            $display("FAIL hold_enter: got outs=%b state=%0d, want 0010 state=4", outs, state_o);
        end
        press_release(2);
        checks++;
        if ({outs, state_o} !== {4'b0100, 3'd2}) begin
            errors++;
            $display("FAIL hold_leave: got outs=%b state=%0d, want 0100 state=2", outs, state_o);
        end
        press_release(3);
        press_release(3);
        checks++;
        if ({outs, state_o} !== {4'b0000, 3'd0}) begin
            errors++;
            $display("FAIL hold_to_idle: got outs=%b state=%0d, want 0000 state=0", outs, state_o);
        end
        press_release(2);
        checks++;
        if ({outs, state_o} !== {4'b0000, 3'd0}) begin
            errors++;
            $display("FAIL hold_in_idle: got outs=%b state=%0d, want 0000 state=0", outs, state_o);
        end
        $display("hold: sequence done, outs=%b", outs);
    endtask

    task automatic test_scan();
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'b0011;
        exp_seq[1] = 4'b0010;
        exp_seq[2] = 4'b0010;
        exp_seq[3] = 4'b0011;
        press_release(3);
        checks++;
        if ({outs, state_o} !== {4'b0011, 3'd5}) begin
            errors++;
            $display("FAIL scan_enter: got outs=%b state=%0d, want 0011 state=5", outs, state_o);
        end
        for (int i = 0; i < 4; i++) begin
            pulse_tick();
            checks++;
            if (outs !== exp_seq[i]) begin
                errors++;
                $display("FAIL scan_tick%0d: got outs=%b, want %b", i + 1, outs, exp_seq[i]);
            end
            $display("scan: tick %0d outs=%b", i + 1, outs);
        end
        press_release(3);
        checks++;
        if ({outs, state_o} !== {4'b0000, 3'd0}) begin
            errors++;
            $display("FAIL scan_exit: got outs=%b state=%0d, want 0000 state=0", outs, state_o);
        end
    endtask

    task automatic test_idle_timeout();
        press_release(0);
        pulse_tick();
        pulse_tick();
        checks++;
        if (outs !== 4'b1000) begin
            errors++;
            $display("FAIL idle_two_ticks: got outs=%b, want 1000", outs);
        end
        pulse_tick();
        checks++;
        if ({outs, state_o} !== {4'b0000, 3'd0}) begin
            errors++;
            $display("FAIL idle_timeout: got outs=%b state=%0d, want 0000 state=0", outs, state_o);
        end
        press_release(0);
        pulse_tick();
        pulse_tick();
        press_release(0);
        pulse_tick();
        pulse_tick();
        checks++;
        if (outs !== 4'b1000) begin
            errors++;
            $display("FAIL idle_restart: got outs=%b, want 1000", outs);
        end
        pulse_tick();
        checks++;
        if ({outs, state_o} !== {4'b0000, 3'd0}) begin
            errors++;
            $display("FAIL idle_restart_timeout: got outs=%b state=%0d, want 0000 state=0", outs, state_o);
        end
        $display("idle_timeout: outs=%b state=%0d", outs, state_o);
    endtask

    task automatic test_simultaneous();
        btn_scan = 1'b1;
        btn_b = 1'b1;
        steps(7);
        checks++;
        if ({outs, state_o} !== {4'b0011, 3'd5}) begin
            errors++;
            $display("FAIL prio_scan_b: got outs=%b state=%0d, want 0011 state=5", outs, state_o);
        end
        btn_scan = 1'b0;
        btn_b = 1'b0;
        steps(8);
        pulse_tick();
        // Hold press (ignored in SCAN) lands on the same edge as a tick.
        btn_hold = 1'b1;
        steps(6);
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        checks++;
        if ({outs, state_o} !== {4'b0011, 3'd5}) begin
            errors++;
            $display("FAIL press_tick_same: got outs=%b state=%0d, want 0011 state=5", outs, state_o);
        end
        btn_hold = 1'b0;
        steps(8);
        pulse_tick();
        checks++;
        if (outs !== 4'b0011) begin
            errors++;
            $display("FAIL dwell_cleared: got outs=%b, want 0011", outs);
        end
        pulse_tick();
        checks++;
        if (outs !== 4'b0010) begin
            errors++;
            $display("FAIL dwell_after_clear: got outs=%b, want 0010", outs);
        end
        $display("simultaneous: outs=%b state=%0d", outs, state_o);
    endtask

    task automatic test_reset_mid();
        pulse_tick();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({outs, state_o} !== {4'b0000, 3'd0}) begin
            errors++;
            $display("FAIL reset_mid_scan: got outs=%b state=%0d, want 0000 state=0", outs, state_o);
        end
        btn_a = 1'b1;
        steps(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (outs !== 4'b0000) begin
                errors++;
                $display("FAIL reset_mid_deb edge %0d: got outs=%b, want 0000", i, outs);
            end
        end
        step();
        checks++;
        if ({outs, state_o} !== {4'b1000, 3'd1}) begin
            errors++;
            $display("FAIL reset_mid_deb_final: got outs=%b state=%0d, want 1000 state=1", outs, state_o);
        end
        $display("reset_mid: outs=%b state=%0d", outs, state_o);
        btn_a = 1'b0;
        steps(8);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_bounce();
        test_hold();
        test_scan();
        test_idle_timeout();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_sel_ctrl.md
# disp_sel_ctrl

Display-selection controller for the dual stopwatch front panel. It turns four raw push-buttons and the 1 Hz tick into the `sela`, `selb`, `hold` and `seldisp` controls of the two-channel display mux. It supports manual channel selection, freeze (hold), timed auto-scan between channels, and an inactivity timeout back to blank. It sits between the button synchronisers/tick generator and the display mux; it never touches the time data itself.

## Interface
Parameters:
- `DEB_CYCLES`, 16: consecutive stable `clk` cycles required to accept a button level.
- `SCAN_SECS`, 4: ticks spent on each channel in SCAN; legal range 1..255.
- `IDLE_SECS`, 60: ticks without a press in SHOW_A/SHOW_B before falling to IDLE; 0 disables the timeout.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `tick_1hz`  in  1  one-cycle pulse, once per second, synchronous to `clk`.
- `btn_a`, `btn_b`, `btn_hold`, `btn_scan`  in  1 each  raw asynchronous button levels, active-high.
- `sela`  out  1  mux select, channel A.
- `selb`  out  1  mux select, channel B.
- `hold`  out  1  mux hold/override.
- `seldisp`  out  1  channel under hold: 1 = A, 0 = B.
- `state_o`  out  3  current FSM state, for debug.

## Operation
- Each button passes through `btn_debounce`: a 2-flop synchroniser, then a stability counter. The debounced level changes only after the synchronised level has differed from it for `DEB_CYCLES` consecutive cycles. A 0→1 change of the debounced level produces a one-cycle `press` pulse.
- States and their registered outputs `{sela, selb, hold, seldisp}`:
  - IDLE: 0000 (mux blanks).
  - SHOW_A: 1000.
  - SHOW_B: 0100.
  - HOLD_A: 0011.
  - HOLD_B: 0010.
  - SCAN: 001x, where `seldisp` is the scan phase.
- `sela` and `selb` are never both 1.
- Press priority within one cycle is scan > hold > a > b. Only the highest-priority press is acted on; lower-priority presses in that cycle are discarded.
- `btn_scan`: from SCAN, go to IDLE. From any other state, go to SCAN with phase = 1 (A) and the dwell counter at 0.
- `btn_hold`:
  - SHOW_A → HOLD_A; SHOW_B → HOLD_B.
  - HOLD_A → SHOW_A; HOLD_B → SHOW_B.
  - Ignored in IDLE and SCAN.
- `btn_a`: go to SHOW_A from any state. `btn_b`: go to SHOW_B from any state.
- SCAN dwell: an 8-bit counter increments on `tick_1hz`. When the count reaches `SCAN_SECS`, the phase toggles and the counter clears to 0 in the same edge.
- Idle timeout: an 8-bit counter runs in SHOW_A/SHOW_B only and increments on `tick_1hz`. When the count reaches `IDLE_SECS` (and `IDLE_SECS` ≠ 0), the FSM goes to IDLE.
  - The counter clears on every state change and on any press.
  - It holds at 0 in all other states.
- Simultaneous events: a press in the same cycle as a tick wins. The tick is ignored for both counters, and both counters clear.

## Timing
- Reset: state IDLE, all outputs 0, `state_o` = 0, counters 0, debounced levels 0, synchronisers 0. Reset asserted mid-debounce or mid-scan discards all progress.
- Button latency: raw level high, sampled at edge 0, stays stable.
  - Synchronised level high after edge 1.
  - Debounce counter reaches `DEB_CYCLES` and `press` asserts after edge 1+`DEB_CYCLES`.
  - State and outputs update at the next edge, 2+`DEB_CYCLES` edges after first sampling.
- A bounce that returns low before the counter saturates resets the counter. No press is generated.
- Tick latency: SCAN phase toggle and idle timeout take effect at the edge that samples the qualifying `tick_1hz`. Outputs change one cycle after that tick.
- A held button produces exactly one press. Release (1→0) produces nothing.

## Structure
- `disp_ctrl_pkg`: state typedef with encodings IDLE=0, SHOW_A=1, SHOW_B=2, HOLD_A=3, HOLD_B=4, SCAN=5; button-index constants; the priority order.
- Sub-module `btn_debounce` (parameter `DEB_CYCLES`; ports `clk`, `rst`, `btn_raw`, `level`, `press`), instantiated four times.
- Top module: FSM, dwell counter, idle counter, registered output decode.

## Test plan
Bench parameters: `DEB_CYCLES`=4, `SCAN_SECS`=2, `IDLE_SECS`=3.
- Reset, then 10 idle cycles → outputs 0000, `state_o`=0. Raise `btn_a` at edge 0 → outputs 1000 exactly after edge 6, never before.
- `btn_a` bounces high 3 cycles, low 1, then high stable → exactly one press. Outputs change 6 edges after the final rise.
- In SHOW_B press `btn_hold` → 0010. Press `btn_hold` again → 0100. Press `btn_hold` in IDLE → no change.
- `btn_scan` → 0011. After 2 ticks → 0010. After 2 more ticks → 0011. `btn_scan` again → 0000.
- SHOW_A with 3 ticks and no press → 0000 one cycle after the third tick. A press of `btn_a` after tick 2 restarts the count.
- `btn_scan` and `btn_b` press pulses in the same cycle → SCAN (0011), not SHOW_B. A tick in the same cycle as a press is ignored by both counters. `rst` asserted mid-SCAN → 0000 at the next edge.
